// File: rtl/mode_counter.sv
// mode_counter: wrap/saturate/bounce up-down counter with runtime limit and load.
// Define COUNTER_PRESCALE_EN to advance only once every PRESCALE enabled cycles.
module mode_counter #(
    parameter int WIDTH    = 24,
    parameter int PRESCALE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             updown,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             dir
);
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("mode_counter: PRESCALE must be in 1..65535");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             dir_q, dir_d;
    logic             advance;
    logic             wrap, bounce;

`ifdef COUNTER_PRESCALE_EN
    logic [15:0] presc_q, presc_d;
    logic        presc_hit;

    always_comb begin
        presc_hit = presc_q == 16'(PRESCALE - 1);
        presc_d   = load ? 16'd0 : enable ? (presc_hit ? 16'd0 : presc_q + 16'd1) : presc_q;
        advance   = enable && !load && presc_hit;
    end

    always_ff @(posedge clock) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end
`else
    assign advance = enable && !load;
`endif

    assign wrap   = mode == 2'b00;
    assign bounce = mode == 2'b10;

    // Out-of-range and limit=0 cases are resolved before the per-mode stepping.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        dir_d   = bounce ? dir_q : updown;
        if (load) begin
            count_d = (load_value > limit) ? limit : load_value;
            dir_d   = dir_q;
        end else if (advance) begin
            if (count_q > limit) begin
                count_d = limit;
                tc_d    = 1'b1;
            end else if (bounce) begin
                if (limit == '0) begin
                    tc_d  = 1'b1;
                    dir_d = !dir_q;
                end else if (dir_q && count_q == limit) begin
                    count_d = limit - WIDTH'(1);
                    dir_d   = 1'b0;
                    tc_d    = 1'b1;
                end else if (!dir_q && count_q == '0) begin
                    count_d = WIDTH'(1);
                    dir_d   = 1'b1;
                    tc_d    = 1'b1;
                end else begin
                    count_d = dir_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                end
            end else if (wrap) begin
                if (updown) begin
                    count_d = (count_q == limit) ? '0 : count_q + WIDTH'(1);
                    tc_d    = count_q == limit;
                end else begin
                    count_d = (count_q == '0) ? limit : count_q - WIDTH'(1);
                    tc_d    = count_q == '0;
                end
            end else if (updown) begin
                count_d = (count_q == limit) ? count_q : count_q + WIDTH'(1);
                tc_d    = count_q != limit && count_q + WIDTH'(1) == limit;
            end else begin
                count_d = (count_q == '0) ? count_q : count_q - WIDTH'(1);
                tc_d    = count_q == WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            dir_q   <= dir_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign dir   = dir_q;
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed scenarios plus randomized run against an integer reference model.
module tb_mode_counter;
    localparam int W = 4;
    localparam int P = 3;

    logic         clock = 1'b0;
    logic         reset, enable, updown, load;
    logic [1:0]   mode;
    logic [W-1:0] limit, load_value, count;
    logic         tc, dir;

    int checks   = 0;
    int failures = 0;

    int m_c = 0;
    int m_p = 0;
    bit m_t = 1'b0;
    bit m_d = 1'b1;

    always #5 clock = ~clock;

    mode_counter #(.WIDTH(W), .PRESCALE(P)) dut (
        .clock(clock), .reset(reset), .enable(enable), .updown(updown), .mode(mode),
        .limit(limit), .load(load), .load_value(load_value),
        .count(count), .tc(tc), .dir(dir)
    );

    // Reference: step the count by +/-1 as an integer, then resolve leaving [0, limit] per mode.
    task automatic model_edge();
        int hi, s, n;
        bit adv;
        if (reset) begin
            m_c = 0; m_t = 0; m_d = 1; m_p = 0;
            return;
        end
        hi  = int'(limit);
        m_t = 0;
        adv = enable && !load;
`ifdef COUNTER_PRESCALE_EN
        if (load) m_p = 0;
        else if (enable) begin
            m_p++;
            if (m_p == P) m_p = 0;
            else adv = 0;
        end
`endif
        if (load) begin
            m_c = (int'(load_value) > hi) ? hi : int'(load_value);
            return;
        end
        if (mode != 2'd2) m_d = updown;
        if (!adv) return;
        s = m_d ? 1 : -1;
        if (m_c > hi) begin
            m_c = hi; m_t = 1;
        end else begin
            n = m_c + s;
            if (n >= 0 && n <= hi) begin
                m_c = n;
                m_t = (mode == 2'd1 || mode == 2'd3) && (n == 0 || n == hi);
            end else if (mode == 2'd0) begin
                m_c = (n < 0) ? hi : 0; m_t = 1;
            end else if (mode == 2'd2) begin
                m_c = (hi == 0) ? 0 : m_c - s; m_d = !m_d; m_t = 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; load = 1; load_value = 7; mode = 2'd2; limit = 9; updown = 0;
        tick();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%0b exp=0", tc); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%0b exp=1", dir); end
        reset = 0; load = 0; enable = 0;
    endtask

    task automatic test_wrap();
        int ec[6] = '{1, 2, 3, 4, 5, 0};
        int et[6] = '{0, 0, 0, 0, 0, 1};
        reset = 1; mode = 2'd0; updown = 1; limit = 5; enable = 1; load = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (count !== W'(ec[i]) || tc !== et[i][0]) begin
                failures++;
                $display("FAIL wrap_step%0d got count=%0d tc=%0b exp count=%0d tc=%0d", i, count, tc, ec[i], et[i]);
            end
        end
    endtask

    task automatic test_saturate();
        int ec[4] = '{1, 0, 0, 0};
        int et[4] = '{0, 1, 0, 0};
        mode = 2'd1; updown = 0; limit = 5; enable = 0; load = 1; load_value = 2;
        tick();
        checks++;
        if (count !== 4'd2 || tc !== 1'b0) begin
            failures++; $display("FAIL sat_load got count=%0d tc=%0b exp count=2 tc=0", count, tc);
        end
        load = 0; enable = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== W'(ec[i]) || tc !== et[i][0]) begin
                failures++;
                $display("FAIL sat_step%0d got count=%0d tc=%0b exp count=%0d tc=%0d", i, count, tc, ec[i], et[i]);
            end
        end
    endtask

    task automatic test_bounce();
        int ec[7] = '{1, 2, 3, 2, 1, 0, 1};
        int et[7] = '{0, 0, 0, 1, 0, 0, 1};
        int ed[7] = '{1, 1, 1, 0, 0, 0, 1};
        reset = 1; mode = 2'd2; limit = 3; enable = 1; load = 0; updown = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (count !== W'(ec[i]) || tc !== et[i][0] || dir !== ed[i][0]) begin
                failures++;
                $display("FAIL bounce_step%0d got count=%0d tc=%0b dir=%0b exp count=%0d tc=%0d dir=%0d",
                         i, count, tc, dir, ec[i], et[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        mode = 2'd2; limit = 3; enable = 1; load = 0; reset = 0;
        repeat (3) tick();
        checks++;
        if (count !== 4'd2 || dir !== 1'b0) begin
            failures++; $display("FAIL rstpri_setup got count=%0d dir=%0b exp count=2 dir=0", count, dir);
        end
        reset = 1; load = 1; load_value = 3;
        tick();
        checks++;
        if (count !== 4'd0 || dir !== 1'b1 || tc !== 1'b0) begin
            failures++; $display("FAIL rstpri got count=%0d dir=%0b tc=%0b exp count=0 dir=1 tc=0", count, dir, tc);
        end
        reset = 0; load = 0;
    endtask

    task automatic test_limit_change();
        mode = 2'd0; updown = 1; limit = 15; enable = 0; load = 1; load_value = 9;
        tick();
        load = 0; limit = 4; enable = 1;
        tick();
        checks++;
        if (count !== 4'd4 || tc !== 1'b1) begin
            failures++; $display("FAIL limit_drop got count=%0d tc=%0b exp count=4 tc=1", count, tc);
        end
        load = 1; load_value = 12;
        tick();
        checks++;
        if (count !== 4'd4 || tc !== 1'b0) begin
            failures++; $display("FAIL load_clamp got count=%0d tc=%0b exp count=4 tc=0", count, tc);
        end
        load = 0;
    endtask

    task automatic test_full_range();
        mode = 2'd0; updown = 1; limit = 15; enable = 0; load = 1; load_value = 14;
        tick();
        load = 0; enable = 1;
        tick();
        checks++; if (count !== 4'd15 || tc !== 1'b0) begin failures++; $display("FAIL full_up15 got count=%0d tc=%0b exp count=15 tc=0", count, tc); end
        tick();
        checks++; if (count !== 4'd0 || tc !== 1'b1) begin failures++; $display("FAIL full_wrap got count=%0d tc=%0b exp count=0 tc=1", count, tc); end
        updown = 0;
        tick();
        checks++; if (count !== 4'd15 || tc !== 1'b1 || dir !== 1'b0) begin failures++; $display("FAIL full_down got count=%0d tc=%0b dir=%0b exp count=15 tc=1 dir=0", count, tc, dir); end
        enable = 0;
        tick();
        checks++; if (count !== 4'd15 || tc !== 1'b0) begin failures++; $display("FAIL hold got count=%0d tc=%0b exp count=15 tc=0", count, tc); end
    endtask

    task automatic test_limit_zero();
        bit d0;
        limit = 0; load = 1; load_value = 6; enable = 0; mode = 2'd0; updown = 1;
        tick();
        load = 0; enable = 1;
        tick();
        checks++; if (count !== 4'd0 || tc !== 1'b1) begin failures++; $display("FAIL lim0_wrap got count=%0d tc=%0b exp count=0 tc=1", count, tc); end
        mode = 2'd1;
        tick();
        checks++; if (count !== 4'd0 || tc !== 1'b0) begin failures++; $display("FAIL lim0_sat got count=%0d tc=%0b exp count=0 tc=0", count, tc); end
        mode = 2'd2; d0 = dir;
        tick();
        checks++; if (count !== 4'd0 || tc !== 1'b1 || dir !== !d0) begin failures++; $display("FAIL lim0_bounce1 got count=%0d tc=%0b dir=%0b exp count=0 tc=1 dir=%0b", count, tc, dir, !d0); end
        tick();
        checks++; if (count !== 4'd0 || tc !== 1'b1 || dir !== d0) begin failures++; $display("FAIL lim0_bounce2 got count=%0d tc=%0b dir=%0b exp count=0 tc=1 dir=%0b", count, tc, dir, d0); end
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale();
        int enabled = 0;
        reset = 1; mode = 2'd0; updown = 1; limit = 15; enable = 1; load = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 14; i++) begin
            enable = (i == 4 || i == 5) ? 1'b0 : 1'b1;
            tick();
            if (enable) enabled++;
            checks++;
            if (count !== W'(enabled / P)) begin
                failures++; $display("FAIL prescale_cyc%0d got count=%0d exp=%0d", i, count, enabled / P);
            end
        end
        enable = 1;
    endtask
`endif

    task automatic test_random();
        reset = 1; load = 0; enable = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(0, 60) == 0);
            load       = ($urandom_range(0, 12) == 0);
            enable     = ($urandom_range(0, 4) != 0);
            updown     = ($urandom_range(0, 3) != 0);
            load_value = W'($urandom);
            if ($urandom_range(0, 25) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 30) == 0) limit = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            tick();
            checks++;
            if (count !== W'(m_c) || tc !== m_t || dir !== m_d) begin
                failures++;
                $display("FAIL random_cyc%0d got count=%0d tc=%0b dir=%0b exp count=%0d tc=%0b dir=%0b",
                         i, count, tc, dir, m_c, m_t, m_d);
            end
        end
    endtask

    initial begin
        reset = 1; enable = 0; updown = 1; load = 0; mode = 2'd0; limit = 5; load_value = 0;
        test_reset();
        test_wrap();
        test_saturate();
        test_bounce();
        test_reset_priority();
        test_limit_change();
        test_full_range();
        test_limit_zero();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
